// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//
// Responder end of the CPU data-memory interface. It accepts one load/store
// request at a time and services it from a word-organised RAM after a fixed
// number of wait states. The result is returned under a valid/ready handshake.
// Transactions are strictly serialised: IDLE -> WAIT -> RESP -> IDLE.
//
// Optional feature macro: DMEM_BOUNDS_CHECK_EN
//   defined   : a request whose address bits above the RAM index are non-zero
//               does not touch the RAM. It responds with rsp_err=1 and
//               rsp_rdata=0, with the same timing as a normal access.
//   undefined : upper address bits are ignored, so the address wraps modulo
//               DEPTH_WORDS, and rsp_err is always 0.
//
// Ports
//   CLK        in   clock, rising edge
//   RESET      in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  responder can accept a request this cycle
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address, bits [1:0] ignored
//   req_be     in   store byte enables
//   req_wdata  in   store data
//   rsp_valid  out  response available
//   rsp_ready  in   initiator consumes the response
//   rsp_rdata  out  load data (0 for stores and rejected requests)
//   rsp_err    out  request rejected by the bounds check
// ---------------------------------------------------------------------------
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t             state_r, next_state_s;
  logic [3:0]         cnt_r, cnt_nxt_s;
  logic               ready_r, valid_r, err_r;
  logic [31:0]        rdata_r;
  logic               we_r, oob_r;
  logic [IDX_W-1:0]   idx_r;
  logic [3:0]         be_r;
  logic [31:0]        wdata_r;
  logic               accept_s, do_access_s, req_oob_s;
  logic               acc_we_s, acc_oob_s;
  logic [IDX_W-1:0]   acc_idx_s;
  logic [3:0]         acc_be_s;
  logic [31:0]        acc_wdata_s;
  logic               unused_addr_s;
  logic [31:0]        mem_r [DEPTH_WORDS];

  // Out-of-range detection on the incoming address
`ifdef DMEM_BOUNDS_CHECK_EN
  assign req_oob_s = |req_addr[31:IDX_W+2];
`else
  assign req_oob_s = 1'b0;
`endif

  // Byte-offset bits (and upper bits when wrapping) are intentionally unused
  assign unused_addr_s = ^{req_addr[31:IDX_W+2], req_addr[1:0]};

  // Next-state logic: accept in IDLE, count down wait states, hold in RESP
  always_comb begin
    next_state_s = state_r;
    cnt_nxt_s    = cnt_r;
    accept_s     = 1'b0;
    do_access_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (req_valid && ready_r) begin
          accept_s  = 1'b1;
          cnt_nxt_s = WAIT_INIT;
          if (WAIT_CYCLES == 0) begin
            // Zero wait states: the access happens on the accept edge itself
            next_state_s = ST_RESP;
            do_access_s  = 1'b1;
          end else begin
            next_state_s = ST_WAIT;
          end
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          next_state_s = ST_RESP;
          do_access_s  = 1'b1;
          cnt_nxt_s    = 4'd0;
        end else begin
          cnt_nxt_s = cnt_r - 4'd1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: begin
        next_state_s = ST_IDLE;
        cnt_nxt_s    = 4'd0;
      end
    endcase
  end

  // Access operand select: live inputs on a zero-wait accept, else latched copy
  always_comb begin
    acc_we_s    = we_r;
    acc_oob_s   = oob_r;
    acc_idx_s   = idx_r;
    acc_be_s    = be_r;
    acc_wdata_s = wdata_r;
    if (state_r == ST_IDLE) begin
      acc_we_s    = req_we;
      acc_oob_s   = req_oob_s;
      acc_idx_s   = req_addr[IDX_W+1:2];
      acc_be_s    = req_be;
      acc_wdata_s = req_wdata;
    end else begin
      acc_we_s    = we_r;
      acc_oob_s   = oob_r;
    end
  end

  // FSM state, wait counter and registered handshake outputs
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_nxt_s;
      ready_r <= (next_state_s == ST_IDLE);
      valid_r <= (next_state_s == ST_RESP);
    end
  end

  // Request capture and response data; response stays frozen until consumed
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      we_r    <= 1'b0;
      oob_r   <= 1'b0;
      idx_r   <= '0;
      be_r    <= 4'd0;
      wdata_r <= 32'd0;
      rdata_r <= 32'd0;
      err_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        we_r    <= req_we;
        oob_r   <= req_oob_s;
        idx_r   <= req_addr[IDX_W+1:2];
        be_r    <= req_be;
        wdata_r <= req_wdata;
      end
      if (do_access_s) begin
        err_r   <= acc_oob_s;
        rdata_r <= (acc_we_s || acc_oob_s) ? 32'd0 : mem_r[acc_idx_s];
      end
    end
  end

  // RAM write port: byte-masked commit, only on the access edge; never reset
  always_ff @(posedge CLK) begin
    if (do_access_s && acc_we_s && !acc_oob_s) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_be_s[b]) begin
          mem_r[acc_idx_s][8*b +: 8] <= acc_wdata_s[8*b +: 8];
        end
      end
    end
  end

  assign req_ready = ready_r;
  assign rsp_valid = valid_r;
  assign rsp_rdata = rdata_r;
  assign rsp_err   = err_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// Self-checking bench for data_mem_responder (default parameters, 2 wait
// states). A reference word memory produces the expected response of every
// request when it is driven. That expectation is queued and then popped and
// compared when rsp_valid appears. Latency is counted in rising edges,
// including the accept edge.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

  localparam int W = 2;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [256];
  logic        pend_we, pend_oob;
  logic [7:0]  pend_idx;
  logic [3:0]  pend_be;
  logic [31:0] pend_wdata;
  logic [31:0] last_rdata;
  int          checks = 0;
  int          errors = 0;

  data_mem_responder dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // Free-running clock
  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present a request, wait (bounded) for acceptance, queue its expectation
  task automatic start_txn(input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
    int   n;
    exp_t e;
    logic oob;
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_be = be; req_wdata = wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    check_val("accept", {31'd0, req_ready}, 32'd1);
`ifdef DMEM_BOUNDS_CHECK_EN
    oob = (addr[31:10] != 22'd0);
`else
    oob = 1'b0;
`endif
    e.err   = oob;
    e.rdata = (we || oob) ? 32'd0 : ref_mem[addr[9:2]];
    exp_q.push_back(e);
    pend_we = we; pend_oob = oob; pend_idx = addr[9:2]; pend_be = be; pend_wdata = wd;
    @(posedge CLK);
    #1 req_valid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid, check latency and pop/compare the response
  task automatic wait_rsp;
    int   edges;
    exp_t e;
    edges = 1;
    @(negedge CLK);
    while (rsp_valid !== 1'b1 && edges < 40) begin
      @(negedge CLK);
      edges++;
    end
    check_val("latency", 32'(edges), 32'(W + 1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("rdata", rsp_rdata, e.rdata);
      check_val("err", {31'd0, rsp_err}, {31'd0, e.err});
    end else begin
      check_val("queue_empty", 32'd0, 32'd1);
    end
    last_rdata = rsp_rdata;
    if (pend_we && !pend_oob) begin
      for (int b = 0; b < 4; b++) begin
        if (pend_be[b]) ref_mem[pend_idx][8*b +: 8] = pend_wdata[8*b +: 8];
      end
    end
  endtask

  // Consume the response; the responder must be back in IDLE next cycle
  task automatic finish_rsp;
    rsp_ready = 1'b1;
    @(posedge CLK);
    #1 rsp_ready = 1'b0;
    @(negedge CLK);
    check_val("rsp_drop", {31'd0, rsp_valid}, 32'd0);
    check_val("ready_back", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic txn(input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wd);
    start_txn(we, addr, be, wd);
    wait_rsp();
    finish_rsp();
  endtask

  initial begin
    logic [31:0] held;
    logic [31:0] a, d;
    int spurious;
    RESET = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_be = 4'd0; req_wdata = 32'd0; rsp_ready = 1'b0;

    // Reset state
    @(negedge CLK);
    check_val("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("rst_rdata", rsp_rdata, 32'd0);
    check_val("rst_err", {31'd0, rsp_err}, 32'd0);
    check_val("rst_ready", {31'd0, req_ready}, 32'd0);
    RESET = 1'b1;
    @(negedge CLK);
    check_val("rel_ready", {31'd0, req_ready}, 32'd1);

    // Full-word store then load
    txn(1'b1, 32'h10, 4'hF, 32'h12345678);
    txn(1'b0, 32'h10, 4'h0, 32'd0);
    check_val("t2_load", last_rdata, 32'h12345678);

    // Partial store, then an all-disabled store that must change nothing
    txn(1'b1, 32'h10, 4'b0101, 32'hAABBCCDD);
    txn(1'b0, 32'h10, 4'h0, 32'd0);
    check_val("t3_merge", last_rdata, 32'h12BB56DD);
    txn(1'b1, 32'h13, 4'b0000, 32'hFFFFFFFF);
    txn(1'b0, 32'h11, 4'h0, 32'd0);
    check_val("t3_be0", last_rdata, 32'h12BB56DD);

    // Backpressure in RESP while an intruding store is presented
    txn(1'b1, 32'h40, 4'hF, 32'h0BADF00D);
    start_txn(1'b0, 32'h10, 4'h0, 32'd0);
    wait_rsp();
    held = rsp_rdata;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_be = 4'hF; req_wdata = 32'hDEADBEEF;
      @(negedge CLK);
      check_val("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_val("bp_rdata", rsp_rdata, held);
      check_val("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid = 1'b0;
    finish_rsp();
    txn(1'b0, 32'h40, 4'h0, 32'd0);
    check_val("bp_ignored", last_rdata, 32'h0BADF00D);

    // Mid-simulation reset while a response is held
    start_txn(1'b0, 32'h10, 4'h0, 32'd0);
    wait_rsp();
    RESET = 1'b0;
    #1;
    check_val("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_val("mid_rst_rdata", rsp_rdata, 32'd0);
    check_val("mid_rst_err", {31'd0, rsp_err}, 32'd0);
    check_val("mid_rst_ready", {31'd0, req_ready}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    check_val("mid_rel_ready", {31'd0, req_ready}, 32'd1);

    // Reset during WAIT of a store aborts it without a response
    txn(1'b1, 32'h20, 4'hF, 32'h5A5A0001);
    start_txn(1'b1, 32'h20, 4'hF, 32'hFFFFFFFF);
    @(negedge CLK);
    RESET = 1'b0;
    exp_q.delete();
    #1;
    check_val("abort_valid", {31'd0, rsp_valid}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    spurious = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      if (rsp_valid !== 1'b0) spurious++;
    end
    check_val("no_spurious", 32'(spurious), 32'd0);
    txn(1'b0, 32'h20, 4'h0, 32'd0);
    check_val("abort_kept", last_rdata, 32'h5A5A0001);

    // Address beyond the RAM: rejected, or aliased onto word 0
    txn(1'b1, 32'h0, 4'hF, 32'h11111111);
    txn(1'b1, 32'h400, 4'hF, 32'hCAFEF00D);
    txn(1'b0, 32'h0, 4'h0, 32'd0);
`ifdef DMEM_BOUNDS_CHECK_EN
    check_val("oob_untouched", last_rdata, 32'h11111111);
`else
    check_val("alias_word0", last_rdata, 32'hCAFEF00D);
`endif

    // Random store/load pairs in the upper half of the RAM
    for (int i = 0; i < 6; i++) begin
      a = {22'd0, 8'($urandom_range(128, 255)), 2'b00};
      d = $urandom;
      txn(1'b1, a, 4'hF, d);
      txn(1'b0, a, 4'h0, 32'd0);
      check_val("rand_load", last_rdata, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
